// File: rtl/tstate_sequencer.sv
// tstate_sequencer: one-hot T-state generator for the control unit.
// Counts steps inside an instruction slot, honours stall / single-step
// enables, latches a sticky halt and a sticky wrap error, and counts
// retired instructions.
module tstate_sequencer #(
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = $clog2(NUM_STEPS),
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run_mode,
    input  logic                 step_req,
    input  logic                 stall,
    input  logic                 end_instr,
    input  logic                 hlt,
    output logic [NUM_STEPS-1:0] T,
    output logic [STEP_W-1:0]    step,
    output logic                 fetch,
    output logic                 halted,
    output logic                 overflow_err,
    output logic [CNT_W-1:0]     instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                halted_q, halted_d;
    logic                en_s;
    logic [NUM_STEPS-1:0] t_s;

    assign en_s = run_mode | step_req;

    // Next-state logic: priority is hlt, then hold (stall / no enable), then end_instr, then advance.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        halted_d = halted_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
                step_d  = {STEP_W{1'b0}};
            end
            ST_RUN: begin
                if (hlt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    step_d   = {STEP_W{1'b0}};
                    if (end_instr) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else if (stall || !en_s) begin
                    // end_instr is deliberately dropped while holding
                    step_d = step_q;
                end else if (end_instr) begin
                    step_d = {STEP_W{1'b0}};
                    cnt_d  = cnt_q + CNT_W'(1);
                end else if (step_q == LAST_STEP) begin
                    // ran off the end of the slot without end_instr
                    step_d = {STEP_W{1'b0}};
                    ovf_d  = 1'b1;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_HALTED: begin
                // only reset leaves HALTED
                state_d = ST_HALTED;
            end
            default: begin
                state_d  = ST_IDLE;
                step_d   = {STEP_W{1'b0}};
                halted_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers, asynchronously cleared by the active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            step_q   <= {STEP_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            ovf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            halted_q <= halted_d;
        end
    end

    // One-hot decode of the registered step, gated to the RUN state.
    always_comb begin
        t_s = {NUM_STEPS{1'b0}};
        if (state_q == ST_RUN) begin
            t_s[step_q] = 1'b1;
        end else begin
            t_s = {NUM_STEPS{1'b0}};
        end
    end

    assign T            = t_s;
    assign fetch        = t_s[0];
    assign step         = step_q;
    assign halted       = halted_q;
    assign overflow_err = ovf_q;
    assign instr_count  = cnt_q;

endmodule

// File: tb/tb_tstate_sequencer.sv
// Directed bench for tstate_sequencer: one 8-step instance driven through
// the main scenarios, one free-running 5-step instance for the
// non-power-of-two wrap.
module tb_tstate_sequencer;

    logic        clk;
    logic        reset;
    logic        run_mode;
    logic        step_req;
    logic        stall;
    logic        end_instr;
    logic        hlt;

    logic [7:0]  a_t;
    logic [2:0]  a_step;
    logic        a_fetch;
    logic        a_halted;
    logic        a_ovf;
    logic [15:0] a_cnt;

    logic [4:0]  b_t;
    logic [2:0]  b_step;
    logic        b_fetch;
    logic        b_halted;
    logic        b_ovf;
    logic [15:0] b_cnt;

    int checks;
    int failures;

    tstate_sequencer #(.NUM_STEPS(8), .CNT_W(16)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .run_mode     (run_mode),
        .step_req     (step_req),
        .stall        (stall),
        .end_instr    (end_instr),
        .hlt          (hlt),
        .T            (a_t),
        .step         (a_step),
        .fetch        (a_fetch),
        .halted       (a_halted),
        .overflow_err (a_ovf),
        .instr_count  (a_cnt)
    );

    tstate_sequencer #(.NUM_STEPS(5), .CNT_W(16)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .run_mode     (1'b1),
        .step_req     (1'b0),
        .stall        (1'b0),
        .end_instr    (1'b0),
        .hlt          (1'b0),
        .T            (b_t),
        .step         (b_step),
        .fetch        (b_fetch),
        .halted       (b_halted),
        .overflow_err (b_ovf),
        .instr_count  (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, return on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int c;
        int bs;
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        run_mode  = 1'b1;
        step_req  = 1'b0;
        stall     = 1'b0;
        end_instr = 1'b0;
        hlt       = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        chk("rst_T",      32'(a_t),      32'h0);
        chk("rst_step",   32'(a_step),   32'h0);
        chk("rst_fetch",  32'(a_fetch),  32'h0);
        chk("rst_halted", 32'(a_halted), 32'h0);
        chk("rst_ovf",    32'(a_ovf),    32'h0);
        chk("rst_cnt",    32'(a_cnt),    32'h0);
        chk("rst_bT",     32'(b_t),      32'h0);

        // release: T stays 0 until the first edge
        reset = 1'b1;
        #1;
        chk("rel_T_pre", 32'(a_t), 32'h0);
        tick();
        chk("rel_T_first",  32'(a_t),     32'h01);
        chk("rel_fetch",    32'(a_fetch), 32'h1);
        chk("rel_b_T",      32'(b_t),     32'h01);

        // ---- free run, end_instr on step 3, 4 instructions; B free-runs mod 5 ----
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 4; s++) begin
                c  = 4 * i + s;
                bs = c % 5;
                chk("run_T",    32'(a_t),   32'(1) << s);
                chk("run_step", 32'(a_step), 32'(s));
                chk("b_step",   32'(b_step), 32'(bs));
                chk("b_T",      32'(b_t),    32'(1) << bs);
                chk("b_ovf",    32'(b_ovf),  (c >= 5) ? 32'h1 : 32'h0);
                chk("b_range",  32'(b_step < 3'd5), 32'h1);
                end_instr = (s == 3);
                tick();
            end
        end
        end_instr = 1'b0;
        chk("run_T_after", 32'(a_t),   32'h01);
        chk("run_cnt4",    32'(a_cnt), 32'd4);
        chk("run_ovf0",    32'(a_ovf), 32'h0);

        // ---- wrap without end_instr ----
        repeat (7) tick();
        chk("wrap_step7",  32'(a_step), 32'd7);
        chk("wrap_T7",     32'(a_t),    32'h80);
        chk("wrap_ovf_pre", 32'(a_ovf), 32'h0);
        tick();
        chk("wrap_step0",  32'(a_step), 32'd0);
        chk("wrap_ovf1",   32'(a_ovf),  32'h1);
        chk("wrap_cnt",    32'(a_cnt),  32'd4);
        tick();
        chk("wrap_step1",  32'(a_step), 32'd1);
        chk("wrap_ovf_sticky", 32'(a_ovf), 32'h1);

        // ---- stall with end_instr at step 2 ----
        tick();
        chk("stall_at2", 32'(a_step), 32'd2);
        stall     = 1'b1;
        end_instr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_hold", 32'(a_step), 32'd2);
            chk("stall_T",    32'(a_t),    32'h04);
            chk("stall_cnt",  32'(a_cnt),  32'd4);
        end
        stall = 1'b0;
        tick();
        end_instr = 1'b0;
        chk("stall_rel_step", 32'(a_step), 32'd0);
        chk("stall_rel_cnt",  32'(a_cnt),  32'd5);

        // ---- single-step: pulse every 4th cycle ----
        run_mode = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 4; k++) begin
                step_req = (k == 3);
                tick();
                chk("ss_step", 32'(a_step), 32'(p + ((k == 3) ? 1 : 0)));
                chk("ss_T",    32'(a_t),    32'(1) << (p + ((k == 3) ? 1 : 0)));
            end
        end
        // stall beats step_req
        stall    = 1'b1;
        step_req = 1'b1;
        tick();
        chk("ss_stall_wins", 32'(a_step), 32'd3);
        // held step_req advances once per cycle
        stall = 1'b0;
        tick();
        tick();
        step_req = 1'b0;
        chk("ss_held2", 32'(a_step), 32'd5);
        tick();
        chk("ss_idle_hold", 32'(a_step), 32'd5);
        run_mode = 1'b1;

        // ---- hlt with end_instr at step 1 ----
        end_instr = 1'b1;
        tick();
        end_instr = 1'b0;
        chk("pre_hlt_cnt", 32'(a_cnt), 32'd6);
        tick();
        chk("pre_hlt_step", 32'(a_step), 32'd1);
        hlt       = 1'b1;
        end_instr = 1'b1;
        tick();
        hlt       = 1'b0;
        end_instr = 1'b0;
        chk("hlt_halted", 32'(a_halted), 32'h1);
        chk("hlt_T",      32'(a_t),      32'h0);
        chk("hlt_fetch",  32'(a_fetch),  32'h0);
        chk("hlt_cnt",    32'(a_cnt),    32'd7);
        stall     = 1'b1;
        step_req  = 1'b1;
        end_instr = 1'b1;
        repeat (3) tick();
        stall     = 1'b0;
        step_req  = 1'b0;
        end_instr = 1'b0;
        chk("hlt_stay",     32'(a_halted), 32'h1);
        chk("hlt_stay_T",   32'(a_t),      32'h0);
        chk("hlt_stay_cnt", 32'(a_cnt),    32'd7);
        chk("hlt_ovf",      32'(a_ovf),    32'h1);

        // ---- asynchronous reset mid-cycle ----
        #2;
        reset = 1'b0;
        #1;
        chk("arst_halted", 32'(a_halted), 32'h0);
        chk("arst_ovf",    32'(a_ovf),    32'h0);
        chk("arst_cnt",    32'(a_cnt),    32'd0);
        chk("arst_step",   32'(a_step),   32'd0);
        chk("arst_T",      32'(a_t),      32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_rel_T", 32'(a_t), 32'h0);
        tick();
        chk("arst_T0",    32'(a_t),     32'h01);
        chk("arst_fetch", 32'(a_fetch), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
